inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//   Instruction fetch stage placed directly ahead of the instruction decoder.
//   - Holds the PC and issues one req/ack read per instruction to instruction memory.
//   - Registers the returned word with a valid/stall handshake and splits out ins_op/func_code.
//   - Accepts PC redirects from branch/jump/jr resolution and flushes wrong-path instructions.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC loaded on reset; bits [1:0] must be 0
// PORTS
//   clk          in   1    clock, all state on rising edge
//   rst_n        in   1    asynchronous active-low reset
//   imem_req     out  1    read request to instruction memory, registered
//   imem_addr    out  32   word address of request, registered, stable while imem_req=1
//   imem_ack     in   1    memory completion; imem_rdata valid in the same cycle
//   imem_rdata   in   32   instruction word
//   redirect     in   1    one-cycle pulse: taken branch/jump, load redirect_pc
//   redirect_pc  in   32   new PC; bits [1:0] ignored (forced 0)
//   stall        in   1    decode not ready; holds the output register
//   if_valid     out  1    if_ins/if_pc hold a live instruction
//   if_ins       out  32   fetched instruction
//   if_pc        out  32   address of if_ins
//   if_pc_plus4  out  32   if_pc+4, modulo 2^32, for jal return address
//   ins_op       out  6    if_ins[31:26], combinational
//   func_code    out  6    if_ins[5:0], combinational
//   fetch_cnt    out  32   delivered-instruction count; present only with FETCH_PERF_CNT_EN
// BEHAVIOUR
//   Reset (async):
//   - pc=RESET_PC, state=READY.
//   - imem_req=0, imem_addr=0, if_valid=0, if_ins=0, if_pc=0, fetch_cnt=0.
//   - Reset mid-request abandons it; imem_req drops immediately.
//   States:
//   - READY: no request outstanding.
//   - BUSY: request outstanding, result wanted.
//   - DROP: request outstanding, result to be discarded.
//   READY:
//   - If redirect: pc<=redirect_pc; no launch.
//   - Else if slot free (!if_valid | !stall): imem_req<=1, imem_addr<=pc, ->BUSY.
//   BUSY:
//   - imem_req and imem_addr hold until ack.
//   - ack & !redirect: imem_req<=0, if_ins<=rdata, if_pc<=imem_addr, if_valid<=1, pc<=imem_addr+4, ->READY.
//   - ack & redirect: imem_req<=0, data discarded, pc<=redirect_pc, ->READY.
//   - !ack & redirect: pc<=redirect_pc, ->DROP.
//   DROP:
//   - Request held until ack; on ack: imem_req<=0, data discarded, ->READY.
//   - A redirect in DROP overwrites pc again.
//   Output register:
//   - Consumed when if_valid & !stall; if_valid<=0 unless a new ack loads it that cycle.
//   - While if_valid & stall, if_ins and if_pc are frozen.
//   - A redirect in any state clears if_valid next cycle (flush); redirect beats ack and stall.
//   Latency and throughput:
//   - Minimum 2 cycles from launch to if_valid (launch cycle, ack cycle).
//   - Peak throughput is one instruction per 2 cycles.
//   Arithmetic: pc+4 wraps 0xFFFFFFFC -> 0x00000000.
//   Slot free at launch guarantees the output register is empty when ack arrives; no overwrite.
// CONFIGURATION
//   FETCH_PERF_CNT_EN
//   - Defined: fetch_cnt port exists.
//   - fetch_cnt increments by 1 on every ack accepted in BUSY without redirect; dropped fetches are not counted.
//   - fetch_cnt wraps at 2^32 and resets to 0.
//   - Undefined: port and counter absent; all other behaviour identical.
// TESTING
//   1. RESET_PC=0x100; release rst_n -> next cycle imem_req=1, imem_addr=0x100. Ack 0x012A4020 ->
//      if_valid=1, if_pc=0x100, if_pc_plus4=0x104, ins_op=0, func_code=0x20.
//   2. Hold stall=1 with if_valid=1 for 5 cycles -> no new request, if_ins stable.
//      Drop stall -> request at 0x104 in the same cycle if_valid falls.
//   3. Redirect to 0x200 while BUSY, ack delayed 3 cycles -> DROP, addr held, data discarded,
//      if_valid=0, next request at 0x200.
//   4. Redirect to 0x200 in the same cycle as ack -> data discarded, next request at 0x200,
//      fetch_cnt unchanged.
//   5. Redirect to 0xFFFFFFFF -> request at 0xFFFFFFFC, then 0x00000000; if_pc_plus4=0 for first.
//   6. Assert rst_n low mid-BUSY -> imem_req=0 and if_valid=0 without a clock edge;
//      restart at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage that sits directly in front of the decoder.
//   It holds the PC and issues one req/ack read per instruction to
//   instruction memory. The returned word is registered behind a
//   valid/stall handshake, and ins_op/func_code are split out of it.
//   PC redirects from branch/jump/jr resolution flush wrong-path work.
//
// Parameters
//   RESET_PC     PC loaded on reset (word aligned)
//
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   registered read request
//   imem_addr    out  32  registered request address, stable while imem_req
//   imem_ack     in   1   memory completion, imem_rdata valid same cycle
//   imem_rdata   in   32  instruction word from memory
//   redirect     in   1   one-cycle pulse, load redirect_pc
//   redirect_pc  in   32  new PC, low two bits forced to zero
//   stall        in   1   decode not ready, hold the output register
//   if_valid     out  1   if_ins/if_pc hold a live instruction
//   if_ins       out  32  fetched instruction
//   if_pc        out  32  address of if_ins
//   if_pc_plus4  out  32  if_pc + 4 (wraps), jal return address
//   ins_op       out  6   if_ins[31:26]
//   func_code    out  6   if_ins[5:0]
//   fetch_cnt    out  32  delivered-instruction count (FETCH_PERF_CNT_EN only)
//
// Configuration
//   FETCH_PERF_CNT_EN  when defined, adds the fetch_cnt port and counter.
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  ins_op,
  output logic [5:0]  func_code
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  // READY: nothing outstanding.
  // BUSY:  request outstanding and its data is wanted.
  // DROP:  request outstanding but its data belongs to a flushed path.
  typedef enum logic [1:0] {
    READY = 2'd0,
    BUSY  = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        req_n;
  logic [31:0] addr_n;
  logic        valid_n;
  logic [31:0] ins_n;
  logic [31:0] ifpc_n;
  logic [31:0] redirect_target;
  logic        slot_free;

  assign redirect_target = redirect_pc & ~32'd3;

  // A launch is allowed only when the output register will be empty by
  // the time the ack can arrive, so a delivered word never overwrites a
  // live one.
  assign slot_free = !if_valid || !stall;

  // Next-state and next-register computation. Redirect has the highest
  // priority: it suppresses a launch, discards data on a simultaneous
  // ack, and always flushes the output register.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = imem_req;
    addr_n  = imem_addr;
    valid_n = if_valid;
    ins_n   = if_ins;
    ifpc_n  = if_pc;

    if (if_valid && !stall) begin
      valid_n = 1'b0;
    end

    case (state)
      READY: begin
        if (redirect) begin
          pc_n = redirect_target;
        end else if (slot_free) begin
          req_n   = 1'b1;
          addr_n  = pc;
          state_n = BUSY;
        end
      end

      BUSY: begin
        if (imem_ack) begin
          req_n   = 1'b0;
          state_n = READY;
          if (redirect) begin
            pc_n = redirect_target;
          end else begin
            ins_n   = imem_rdata;
            ifpc_n  = imem_addr;
            valid_n = 1'b1;
            pc_n    = imem_addr + 32'd4;
          end
        end else if (redirect) begin
          pc_n    = redirect_target;
          state_n = DROP;
        end
      end

      DROP: begin
        if (redirect) begin
          pc_n = redirect_target;
        end
        if (imem_ack) begin
          req_n   = 1'b0;
          state_n = READY;
        end
      end

      default: begin
        state_n = READY;
        req_n   = 1'b0;
      end
    endcase

    if (redirect) begin
      valid_n = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= READY;
      pc        <= RESET_PC_ALIGNED;
      imem_req  <= 1'b0;
      imem_addr <= 32'd0;
      if_valid  <= 1'b0;
      if_ins    <= 32'd0;
      if_pc     <= 32'd0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      if_valid  <= valid_n;
      if_ins    <= ins_n;
      if_pc     <= ifpc_n;
    end
  end

  assign if_pc_plus4 = if_pc + 32'd4;
  assign ins_op      = if_ins[31:26];
  assign func_code   = if_ins[5:0];

`ifdef FETCH_PERF_CNT_EN
  logic count_en;

  // Only words actually handed to the output register count; fetches
  // dropped by a redirect do not.
  assign count_en = (state == BUSY) && imem_ack && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'd0;
    end else if (count_en) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

  // The request address must not move while the memory is working on it.
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_ack) |=> (imem_addr == $past(imem_addr)));

  // A request is outstanding exactly when the FSM is not in READY.
  a_req_state: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req == (state != READY));

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [5:0]  ins_op;
  logic [5:0]  func_code;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_ins      (if_ins),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .ins_op      (ins_op),
    .func_code   (func_code)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Directed vector: inputs for the cycle plus the outputs expected at
  // the start of that cycle (before those inputs take effect).
  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        stl;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata,
                              input logic redir, input logic [31:0] rpc,
                              input logic stl, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_pc, input logic [31:0] e_ins,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.ack = ack;     v.rdata = rdata;   v.redir = redir; v.rpc = rpc;
    v.stl = stl;     v.e_req = e_req;   v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_ins = e_ins; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Contents of the pretend instruction memory.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic redir, input logic [31:0] rpc,
                               input logic stl);
    imem_ack    = ack;
    imem_rdata  = rdata;
    redirect    = redir;
    redirect_pc = rpc;
    stall       = stl;
  endtask

  task automatic checkInstr(input string tag, input logic [31:0] e_pc,
                            input logic [31:0] e_ins);
    logic [31:0] ins_copy;
    ins_copy = e_ins;
    checkOutput({tag, "_pc"},    if_pc,       e_pc);
    checkOutput({tag, "_ins"},   if_ins,      e_ins);
    checkOutput({tag, "_plus4"}, if_pc_plus4, e_pc + 32'd4);
    checkOutput({tag, "_op"},    {26'd0, ins_op},    {26'd0, ins_copy[31:26]});
    checkOutput({tag, "_func"},  {26'd0, func_code}, {26'd0, ins_copy[5:0]});
  endtask

  // Reference model state for the randomized phase.
  logic        m_req, m_valid, m_wanted;
  logic [31:0] m_addr, m_ins, m_ifpc, m_fetch, m_cnt;

  initial begin
    logic        ack, redir, stl;
    logic [31:0] rdata, rpc;
    logic        n_req, n_valid;
    logic [31:0] n_addr, n_ins, n_ifpc;

    // Directed sequence: startup fetch, 5-cycle stall, redirect while busy
    // with late ack, redirect coincident with ack, wrap at 0xFFFFFFFC.
    vecs[0]  = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0,         0);
    vecs[1]  = mk(1, 32'h012A_4020, 0, 32'h0,         0, 1, 32'h100,       0, 32'h0,         32'h0,         0);
    vecs[2]  = mk(0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       32'h012A_4020, 1);
    vecs[3]  = mk(0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       32'h012A_4020, 1);
    vecs[4]  = mk(0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       32'h012A_4020, 1);
    vecs[5]  = mk(0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       32'h012A_4020, 1);
    vecs[6]  = mk(0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       32'h012A_4020, 1);
    vecs[7]  = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h100,       32'h012A_4020, 1);
    vecs[8]  = mk(0, 32'h0,         1, 32'h200,       0, 1, 32'h104,       0, 32'h0,         32'h0,         1);
    vecs[9]  = mk(0, 32'h0,         0, 32'h0,         0, 1, 32'h104,       0, 32'h0,         32'h0,         1);
    vecs[10] = mk(0, 32'h0,         0, 32'h0,         0, 1, 32'h104,       0, 32'h0,         32'h0,         1);
    vecs[11] = mk(1, 32'hDEAD_BEEF, 0, 32'h0,         0, 1, 32'h104,       0, 32'h0,         32'h0,         1);
    vecs[12] = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0,         1);
    vecs[13] = mk(1, 32'h1111_1111, 1, 32'h200,       0, 1, 32'h200,       0, 32'h0,         32'h0,         1);
    vecs[14] = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0,         1);
    vecs[15] = mk(1, 32'h0800_0040, 0, 32'h0,         0, 1, 32'h200,       0, 32'h0,         32'h0,         1);
    vecs[16] = mk(0, 32'h0,         1, 32'hFFFF_FFFF, 1, 0, 32'h0,         1, 32'h200,       32'h0800_0040, 2);
    vecs[17] = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0,         2);
    vecs[18] = mk(1, 32'h03E0_0008, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         2);
    vecs[19] = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h03E0_0008, 3);
    vecs[20] = mk(1, 32'h2042_0001, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0,         32'h0,         3);
    vecs[21] = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         32'h2042_0001, 4);
    vecs[22] = mk(0, 32'h0,         0, 32'h0,         0, 1, 32'h4,         0, 32'h0,         32'h0,         4);

    rst_n = 1'b0;
    applyStimulus(0, 32'h0, 0, 32'h0, 0);
    #2;
    checkOutput("reset_req",   {31'd0, imem_req}, 32'd0);
    checkOutput("reset_addr",  imem_addr,         32'd0);
    checkOutput("reset_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("reset_ins",   if_ins,            32'd0);
    checkOutput("reset_pc",    if_pc,             32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("reset_cnt",   fetch_cnt,         32'd0);
`endif

    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      checkOutput($sformatf("vec%0d_req", i),   {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      if (vecs[i].e_req)
        checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_valid)
        checkInstr($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ins);
`ifdef FETCH_PERF_CNT_EN
      checkOutput($sformatf("vec%0d_cnt", i), fetch_cnt, vecs[i].e_cnt);
`endif
      applyStimulus(vecs[i].ack, vecs[i].rdata, vecs[i].redir, vecs[i].rpc, vecs[i].stl);
    end

    // Asynchronous reset while a request is outstanding.
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req",   {31'd0, imem_req}, 32'd0);
    checkOutput("async_rst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("async_rst_addr",  imem_addr,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("restart_req",  {31'd0, imem_req}, 32'd1);
    checkOutput("restart_addr", imem_addr,         RST_PC);

    // Randomized phase against the transaction-level reference model.
    rst_n = 1'b0;
    applyStimulus(0, 32'h0, 0, 32'h0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_req = 0; m_valid = 0; m_wanted = 0;
    m_addr = 0; m_ins = 0; m_ifpc = 0; m_fetch = RST_PC; m_cnt = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      checkOutput("rnd_req",   {31'd0, imem_req}, {31'd0, m_req});
      if (m_req)
        checkOutput("rnd_addr", imem_addr, m_addr);
      checkOutput("rnd_valid", {31'd0, if_valid}, {31'd0, m_valid});
      if (m_valid)
        checkInstr("rnd", m_ifpc, m_ins);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("rnd_cnt", fetch_cnt, m_cnt);
`endif

      stl   = ($urandom_range(0, 99) < 35);
      redir = ($urandom_range(0, 99) < 8);
      rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                          : $urandom;
      ack   = imem_req && ($urandom_range(0, 99) < 45);
      rdata = ack ? mem_word(imem_addr) : $urandom;
      applyStimulus(ack, rdata, redir, rpc, stl);

      // One in-flight fetch at a time; its data is delivered only if no
      // redirect happened since it was issued and none arrives with the ack.
      n_req = m_req; n_addr = m_addr; n_valid = m_valid;
      n_ins = m_ins; n_ifpc = m_ifpc;
      if (m_valid && !stl) n_valid = 0;
      if (m_req) begin
        if (ack) begin
          n_req = 0;
          if (!redir && m_wanted) begin
            n_valid = 1;
            n_ins   = mem_word(m_addr);
            n_ifpc  = m_addr;
            m_fetch = m_addr + 32'd4;
            m_cnt   = m_cnt + 32'd1;
          end
        end
      end else if (!redir && (!m_valid || !stl)) begin
        n_req    = 1;
        n_addr   = m_fetch;
        m_wanted = 1;
      end
      if (redir) begin
        m_fetch  = rpc & ~32'd3;
        m_wanted = 0;
        n_valid  = 0;
      end
      m_req = n_req; m_addr = n_addr; m_valid = n_valid;
      m_ins = n_ins; m_ifpc = n_ifpc;

      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
